// File: rtl/hit_result_collector.sv
// Collects per-ray closest-hit results behind the ray-tracing top, checks each first
// occurrence against a preloaded golden hitT table and reports counters plus done/pass.
module hit_result_collector #(
  parameter int NUM_RAYS = 1024,
  parameter int ID_W     = 10,
  parameter int ULP_TOL  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [31:0]     io_in_ray_id,
  input  logic [31:0]     io_in_hitT,
  input  logic            io_rtp_finish,
  input  logic            io_exp_wr_en,
  input  logic [ID_W-1:0] io_exp_wr_addr,
  input  logic [31:0]     io_exp_wr_data,
  input  logic [ID_W-1:0] io_rd_addr,
  output logic [31:0]     io_rd_data,
  output logic [31:0]     io_ray_count,
  output logic [31:0]     io_mismatch_count,
  output logic [31:0]     io_dup_count,
  output logic [31:0]     io_first_mismatch_id,
  output logic [63:0]     io_cycle_count,
  output logic            io_done,
  output logic            io_pass
);

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(NUM_RAYS - 1);
  localparam logic [31:0]     NUM_RAYS_W = 32'(NUM_RAYS);
  localparam logic [30:0]     TOL_W      = 31'(ULP_TOL);

  logic [31:0] golden_mem [NUM_RAYS];
  logic [31:0] result_mem [NUM_RAYS];
  logic        seen_mem   [NUM_RAYS];

  state_t          state_q, state_d;
  logic [ID_W-1:0] clr_idx_q, clr_idx_d;
  logic            s2_valid_q, s2_valid_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic            s2_in_range_q, s2_in_range_d;
  logic            s2_seen_q, s2_seen_d;
  logic [31:0]     s2_hit_q, s2_hit_d;
  logic [31:0]     s2_gold_q, s2_gold_d;
  logic [31:0]     ray_count_q, ray_count_d;
  logic [31:0]     mismatch_count_q, mismatch_count_d;
  logic [31:0]     dup_count_q, dup_count_d;
  logic [31:0]     first_mm_q, first_mm_d;
  logic [63:0]     cycle_count_q, cycle_count_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [31:0]     rd_data_q, rd_data_d;

  logic [ID_W-1:0] s1_id;
  logic            s1_fwd_seen;
  logic [30:0]     mag_a, mag_b, mag_diff;
  logic            is_match, s2_we, s2_first, s2_dup;

  // S1: capture the beat and its golden/seen lookups; a same-id beat still in S2
  // has not yet set its seen bit, so forward it here.
  always_comb begin
    s1_id         = io_in_ray_id[ID_W-1:0];
    s1_fwd_seen   = s2_valid_q && s2_in_range_q && (s2_id_q == s1_id);
    s2_valid_d    = io_in_valid && (state_q == S_COLLECT);
    s2_id_d       = s1_id;
    s2_in_range_d = (io_in_ray_id < NUM_RAYS_W);
    s2_seen_d     = seen_mem[s1_id] || s1_fwd_seen;
    s2_hit_d      = io_in_hitT;
    s2_gold_d     = golden_mem[s1_id];
    rd_data_d     = result_mem[io_rd_addr];
  end

  always_comb begin
    mag_a            = s2_gold_q[30:0];
    mag_b            = s2_hit_q[30:0];
    mag_diff         = (mag_a >= mag_b) ? (mag_a - mag_b) : (mag_b - mag_a);
    is_match         = (s2_gold_q == s2_hit_q) ||
                       ((mag_a == '0) && (mag_b == '0)) ||
                       ((s2_gold_q[31] == s2_hit_q[31]) && (mag_diff <= TOL_W));
    s2_we            = s2_valid_q && s2_in_range_q;
    s2_first         = s2_we && !s2_seen_q;
    s2_dup           = s2_valid_q && (!s2_in_range_q || s2_seen_q);
    ray_count_d      = ray_count_q;
    mismatch_count_d = mismatch_count_q;
    dup_count_d      = dup_count_q;
    first_mm_d       = first_mm_q;
    cycle_count_d    = cycle_count_q;
    if (s2_first && (ray_count_q != '1)) ray_count_d = ray_count_q + 32'd1;
    if (s2_first && !is_match) begin
      if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + 32'd1;
      if (first_mm_q == '1) first_mm_d = 32'(s2_id_q);
    end
    if (s2_dup && (dup_count_q != '1)) dup_count_d = dup_count_q + 32'd1;
    if (((state_q == S_COLLECT) || (state_q == S_DRAIN)) && (cycle_count_q != '1))
      cycle_count_d = cycle_count_q + 64'd1;
  end

  // The verdict is taken only once S2 is empty so every counter is final.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      S_CLR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE:    state_d = S_COLLECT;
      S_COLLECT: if (io_rtp_finish || (ray_count_d == NUM_RAYS_W)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!s2_valid_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (mismatch_count_q == '0) && (dup_count_q == '0) &&
                    (ray_count_q == NUM_RAYS_W);
        end
      end
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_CLR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_CLR;
      clr_idx_q        <= '0;
      s2_valid_q       <= 1'b0;
      s2_id_q          <= '0;
      s2_in_range_q    <= 1'b0;
      s2_seen_q        <= 1'b0;
      s2_hit_q         <= '0;
      s2_gold_q        <= '0;
      ray_count_q      <= '0;
      mismatch_count_q <= '0;
      dup_count_q      <= '0;
      first_mm_q       <= '1;
      cycle_count_q    <= '0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      rd_data_q        <= '0;
    end else begin
      state_q          <= state_d;
      clr_idx_q        <= clr_idx_d;
      s2_valid_q       <= s2_valid_d;
      s2_id_q          <= s2_id_d;
      s2_in_range_q    <= s2_in_range_d;
      s2_seen_q        <= s2_seen_d;
      s2_hit_q         <= s2_hit_d;
      s2_gold_q        <= s2_gold_d;
      ray_count_q      <= ray_count_d;
      mismatch_count_q <= mismatch_count_d;
      dup_count_q      <= dup_count_d;
      first_mm_q       <= first_mm_d;
      cycle_count_q    <= cycle_count_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      rd_data_q        <= rd_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (io_exp_wr_en) golden_mem[io_exp_wr_addr] <= io_exp_wr_data;
  end

  // A beat caught in S2 by reset is discarded rather than written.
  always_ff @(posedge clock) begin
    if (s2_we && !reset) result_mem[s2_id_q] <= s2_hit_q;
  end

  always_ff @(posedge clock) begin
    if (state_q == S_CLR) seen_mem[clr_idx_q] <= 1'b0;
    else if (s2_we && !reset) seen_mem[s2_id_q] <= 1'b1;
  end

  assign io_in_ready          = (state_q == S_COLLECT);
  assign io_rd_data           = rd_data_q;
  assign io_ray_count         = ray_count_q;
  assign io_mismatch_count    = mismatch_count_q;
  assign io_dup_count         = dup_count_q;
  assign io_first_mismatch_id = first_mm_q;
  assign io_cycle_count       = cycle_count_q;
  assign io_done              = done_q;
  assign io_pass              = pass_q;

endmodule

// File: tb/tb_hit_result_collector.sv
// Self-checking bench for hit_result_collector: randomized beats scored against a
// plain array/counter model of the collection and compare rules.
module tb_hit_result_collector;

  localparam int NUM_RAYS = 1024;
  localparam int ID_W     = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            io_in_valid = 1'b0;
  logic            io_in_ready;
  logic [31:0]     io_in_ray_id = '0;
  logic [31:0]     io_in_hitT = '0;
  logic            io_rtp_finish = 1'b0;
  logic            io_exp_wr_en = 1'b0;
  logic [ID_W-1:0] io_exp_wr_addr = '0;
  logic [31:0]     io_exp_wr_data = '0;
  logic [ID_W-1:0] io_rd_addr = '0;
  logic [31:0]     io_rd_data;
  logic [31:0]     io_ray_count;
  logic [31:0]     io_mismatch_count;
  logic [31:0]     io_dup_count;
  logic [31:0]     io_first_mismatch_id;
  logic [63:0]     io_cycle_count;
  logic            io_done;
  logic            io_pass;

  hit_result_collector #(.NUM_RAYS(NUM_RAYS), .ID_W(ID_W), .ULP_TOL(2)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_ray_id(io_in_ray_id), .io_in_hitT(io_in_hitT),
    .io_rtp_finish(io_rtp_finish),
    .io_exp_wr_en(io_exp_wr_en), .io_exp_wr_addr(io_exp_wr_addr),
    .io_exp_wr_data(io_exp_wr_data),
    .io_rd_addr(io_rd_addr), .io_rd_data(io_rd_data),
    .io_ray_count(io_ray_count), .io_mismatch_count(io_mismatch_count),
    .io_dup_count(io_dup_count), .io_first_mismatch_id(io_first_mismatch_id),
    .io_cycle_count(io_cycle_count), .io_done(io_done), .io_pass(io_pass)
  );

  always #5 clock = ~clock;

  int unsigned tb_cyc = 0;
  always @(posedge clock) tb_cyc <= tb_cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] golden_m [NUM_RAYS];
  logic [31:0] result_m [NUM_RAYS];
  bit          known_m  [NUM_RAYS];
  bit          seen_m   [NUM_RAYS];
  int          m_ray, m_mm, m_dup;
  logic [31:0] m_first;
  int unsigned t_collect, t_done;

  function automatic bit model_match(logic [31:0] g, logic [31:0] h);
    longint ma, mb;
    ma = longint'(g[30:0]);
    mb = longint'(h[30:0]);
    if (g == h) return 1'b1;
    if (ma == 0 && mb == 0) return 1'b1;
    if (g[31] == h[31] && (ma - mb) <= 2 && (mb - ma) <= 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_RAYS; i++) seen_m[i] = 1'b0;
    m_ray = 0; m_mm = 0; m_dup = 0;
    m_first = 32'hFFFF_FFFF;
  endtask

  task automatic model_beat(input logic [31:0] id, input logic [31:0] hit);
    if (id >= 32'(NUM_RAYS)) begin
      m_dup++;
    end else begin
      result_m[id] = hit;
      known_m[id]  = 1'b1;
      if (seen_m[id]) begin
        m_dup++;
      end else begin
        seen_m[id] = 1'b1;
        m_ray++;
        if (!model_match(golden_m[id], hit)) begin
          m_mm++;
          if (m_first == 32'hFFFF_FFFF) m_first = id;
        end
      end
    end
  endtask

  task automatic drive_beat(input logic [31:0] id, input logic [31:0] hit);
    @(negedge clock);
    io_in_valid  = 1'b1;
    io_in_ray_id = id;
    io_in_hitT   = hit;
    model_beat(id, hit);
  endtask

  task automatic drive_idle();
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  task automatic golden_write(input int addr, input logic [31:0] data);
    @(negedge clock);
    io_exp_wr_en   = 1'b1;
    io_exp_wr_addr = ID_W'(addr);
    io_exp_wr_data = data;
    golden_m[addr] = data;
  endtask

  task automatic golden_idle();
    @(negedge clock);
    io_exp_wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    io_in_valid = 1'b0;
    io_rtp_finish = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic pulse_finish();
    @(negedge clock);
    io_in_valid = 1'b0;
    io_rtp_finish = 1'b1;
    @(negedge clock);
    io_rtp_finish = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (io_in_ready !== 1'b1 && n < 1500) begin
      @(negedge clock);
      n++;
    end
    t_collect = tb_cyc;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (io_done !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    t_done = tb_cyc;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_clear();
    vectors += 8;
    if (io_ray_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_ray_count got %h want 0", io_ray_count); end
    if (io_mismatch_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_mismatch got %h want 0", io_mismatch_count); end
    if (io_dup_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_dup got %h want 0", io_dup_count); end
    if (io_first_mismatch_id !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL reset_first_mm got %h want ffffffff", io_first_mismatch_id); end
    if (io_cycle_count !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_cycle got %h want 0", io_cycle_count); end
    if ({io_done, io_pass, io_in_ready} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 000", {io_done, io_pass, io_in_ready}); end
    if (io_rd_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rd_data got %h want 0", io_rd_data); end
    wait_ready(n);
    if (n !== NUM_RAYS + 1) begin miscompares++; $display("[TB] FAIL reset_clear_len got %0d want %0d", n, NUM_RAYS + 1); end
  endtask

  task automatic test_full_run();
    int n;
    logic [31:0] cyc_snap;
    for (int i = 0; i < NUM_RAYS; i++) golden_write(i, 32'h3F80_0000 + 32'(i));
    golden_idle();
    for (int i = 0; i < NUM_RAYS; i++) drive_beat(32'(i), golden_m[i]);
    drive_idle();
    wait_done(n);
    vectors += 8;
    if (n > 2) begin miscompares++; $display("[TB] FAIL full_done_latency got %0d want <=2", n); end
    if (io_ray_count !== 32'(m_ray)) begin miscompares++; $display("[TB] FAIL full_ray_count got %0d want %0d", io_ray_count, m_ray); end
    if (io_mismatch_count !== 32'(m_mm)) begin miscompares++; $display("[TB] FAIL full_mismatch got %0d want %0d", io_mismatch_count, m_mm); end
    if (io_dup_count !== 32'(m_dup)) begin miscompares++; $display("[TB] FAIL full_dup got %0d want %0d", io_dup_count, m_dup); end
    if (io_first_mismatch_id !== m_first) begin miscompares++; $display("[TB] FAIL full_first_mm got %h want %h", io_first_mismatch_id, m_first); end
    if (io_pass !== (m_mm == 0 && m_dup == 0 && m_ray == NUM_RAYS)) begin miscompares++; $display("[TB] FAIL full_pass got %b want 1", io_pass); end
    if (io_cycle_count !== 64'(t_done - t_collect)) begin miscompares++; $display("[TB] FAIL full_cycles got %0d want %0d", io_cycle_count, t_done - t_collect); end
    cyc_snap = io_cycle_count[31:0];
    repeat (5) @(negedge clock);
    if (io_cycle_count[31:0] !== cyc_snap || io_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_frozen got %0d/%b want %0d/0", io_cycle_count, io_in_ready, cyc_snap); end
    for (int k = 0; k < 16; k++) begin
      int a;
      a = int'($urandom_range(0, NUM_RAYS - 1));
      @(negedge clock);
      io_rd_addr = ID_W'(a);
      @(negedge clock);
      vectors++;
      if (io_rd_data !== result_m[a]) begin miscompares++; $display("[TB] FAIL full_readback[%0d] got %h want %h", a, io_rd_data, result_m[a]); end
    end
  endtask

  task automatic test_tolerance();
    int n;
    logic [31:0] h;
    int id, off;
    pulse_reset();
    golden_write(5, 32'h4000_0000);
    golden_write(6, 32'h4000_0000);
    golden_write(10, 32'h0000_0000);
    golden_write(11, 32'h3F80_0000);
    golden_idle();
    wait_ready(n);
    drive_beat(32'd5, 32'h4000_0002);
    drive_beat(32'd6, 32'h4000_0003);
    drive_beat(32'd9, 32'h3F80_000D);
    drive_beat(32'd10, 32'h8000_0000);
    drive_beat(32'd11, 32'hBF80_0000);
    for (int k = 0; k < 40; k++) begin
      id  = int'($urandom_range(100, 299));
      off = int'($urandom_range(0, 8)) - 4;
      h   = golden_m[id] + 32'(off);
      if ($urandom_range(0, 7) == 0) h[31] = ~h[31];
      drive_beat(32'(id), h);
    end
    pulse_finish();
    wait_done(n);
    vectors += 6;
    if (n >= 50) begin miscompares++; $display("[TB] FAIL tol_done_timeout got %0d want <50", n); end
    if (io_mismatch_count !== 32'(m_mm)) begin miscompares++; $display("[TB] FAIL tol_mismatch got %0d want %0d", io_mismatch_count, m_mm); end
    if (io_first_mismatch_id !== 32'd6) begin miscompares++; $display("[TB] FAIL tol_first_mm got %h want 6", io_first_mismatch_id); end
    if (io_ray_count !== 32'(m_ray)) begin miscompares++; $display("[TB] FAIL tol_ray_count got %0d want %0d", io_ray_count, m_ray); end
    if (io_dup_count !== 32'(m_dup)) begin miscompares++; $display("[TB] FAIL tol_dup got %0d want %0d", io_dup_count, m_dup); end
    if (io_pass !== 1'b0) begin miscompares++; $display("[TB] FAIL tol_pass got %b want 0", io_pass); end
  endtask

  task automatic test_back_to_back();
    int n;
    int id;
    int addrs [3];
    pulse_reset();
    wait_ready(n);
    drive_beat(32'd7, $urandom);
    drive_beat(32'd7, $urandom);
    drive_beat(32'd2000, $urandom);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) id = int'($urandom_range(1024, 1500));
      else id = int'($urandom_range(100, 900));
      drive_beat(32'(id), (k % 3 == 0) ? golden_m[id < NUM_RAYS ? id : 0] : $urandom);
    end
    pulse_finish();
    wait_done(n);
    vectors += 5;
    if (n >= 50) begin miscompares++; $display("[TB] FAIL b2b_done_timeout got %0d want <50", n); end
    if (io_dup_count !== 32'(m_dup)) begin miscompares++; $display("[TB] FAIL b2b_dup got %0d want %0d", io_dup_count, m_dup); end
    if (io_ray_count !== 32'(m_ray)) begin miscompares++; $display("[TB] FAIL b2b_ray_count got %0d want %0d", io_ray_count, m_ray); end
    if (io_mismatch_count !== 32'(m_mm)) begin miscompares++; $display("[TB] FAIL b2b_mismatch got %0d want %0d", io_mismatch_count, m_mm); end
    if (io_first_mismatch_id !== m_first) begin miscompares++; $display("[TB] FAIL b2b_first_mm got %h want %h", io_first_mismatch_id, m_first); end
    addrs[0] = 7; addrs[1] = 2000 % NUM_RAYS; addrs[2] = int'($urandom_range(0, 99));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      io_rd_addr = ID_W'(addrs[k]);
      @(negedge clock);
      vectors++;
      if (io_rd_data !== result_m[addrs[k]]) begin miscompares++; $display("[TB] FAIL b2b_readback[%0d] got %h want %h", addrs[k], io_rd_data, result_m[addrs[k]]); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [31:0] cyc_snap;
    pulse_reset();
    wait_ready(n);
    for (int i = 0; i < 20; i++) drive_beat(32'(i), $urandom);
    drive_idle();
    pulse_reset();
    vectors += 5;
    if (io_ray_count !== 32'd0 || io_mismatch_count !== 32'd0 || io_dup_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL mid_counters got %0d/%0d/%0d want 0/0/0", io_ray_count, io_mismatch_count, io_dup_count);
    end
    if (io_first_mismatch_id !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL mid_first_mm got %h want ffffffff", io_first_mismatch_id); end
    wait_ready(n);
    if (n !== NUM_RAYS + 1) begin miscompares++; $display("[TB] FAIL mid_clear_len got %0d want %0d", n, NUM_RAYS + 1); end
    for (int i = 0; i < 10; i++) drive_beat(32'(i), golden_m[i]);
    pulse_finish();
    wait_done(n);
    if (io_ray_count !== 32'(m_ray) || io_dup_count !== 32'(m_dup)) begin
      miscompares++; $display("[TB] FAIL mid_rerun_counts got %0d/%0d want %0d/%0d", io_ray_count, io_dup_count, m_ray, m_dup);
    end
    if (io_pass !== 1'b0 || io_done !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_verdict got done=%b pass=%b want 1/0", io_done, io_pass); end
    cyc_snap = io_cycle_count[31:0];
    repeat (5) @(negedge clock);
    vectors += 2;
    if (io_cycle_count !== 64'(t_done - t_collect) || io_cycle_count[31:0] !== cyc_snap) begin
      miscompares++; $display("[TB] FAIL mid_cycles got %0d want %0d", io_cycle_count, t_done - t_collect);
    end
    if (io_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ready_after got %b want 0", io_in_ready); end
  endtask

  initial begin
    for (int i = 0; i < NUM_RAYS; i++) known_m[i] = 1'b0;
    test_reset();
    test_full_run();
    test_tolerance();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", tb_cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
